// File: rtl/framebuffer_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter and its three neighbours:
// VGA scan-out fetch, pixel-processor request channel and the image SRAM port.
interface framebuffer_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
);
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;

  logic              cpu_valid;
  logic              cpu_ready;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  vga_req, vga_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vga_data, vga_valid, cpu_ready, cpu_rdata, cpu_rvalid,
           mem_addr, mem_we, mem_wdata
  );

  modport master (
    output vga_req, vga_addr, cpu_valid, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vga_data, vga_valid, cpu_ready, cpu_rdata, cpu_rvalid,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/framebuffer_arbiter.sv
// Single-port frame-buffer SRAM arbiter: VGA fetch has absolute priority, the pixel
// processor reads in idle slots and its writes drain from a small FIFO.
module framebuffer_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 8,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  framebuffer_arbiter_if.slave         bus,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count,
  output logic                         vga_overrun
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, RD_PEND} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_VGA, OWN_CPU} owner_t;

  state_t            state_q, state_d;
  owner_t            tag_p1_q, tag_p1_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] last_wdata_q, last_wdata_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] vga_data_q, vga_data_d, cpu_rdata_q, cpu_rdata_d;
  logic              vga_valid_q, vga_valid_d, cpu_rvalid_q, cpu_rvalid_d;
  logic              vga_req_prev_q, overrun_q, overrun_d;

  logic [ADDR_W-1:0] wbuf_addr_q [WBUF_DEPTH];
  logic [DATA_W-1:0] wbuf_data_q [WBUF_DEPTH];

  logic wbuf_empty, wbuf_full;
  logic grant_vga, grant_rd, grant_wr;
  logic ready, push, rd_accept;

  // Stage p0: slot grant and request acceptance, all from this cycle's inputs.
  // Grants are masked by rst_n so the SRAM port is quiet while reset is held.
  always_comb begin
    wbuf_empty = (count_q == '0);
    wbuf_full  = (count_q == CNT_W'(WBUF_DEPTH));
    grant_vga  = rst_n && bus.vga_req;
    grant_rd   = rst_n && !bus.vga_req && (state_q == RD_PEND);
    grant_wr   = rst_n && !bus.vga_req && (state_q == IDLE) && !wbuf_empty;
    // Reads wait for an empty buffer so they always observe earlier writes.
    ready      = rst_n && (state_q == IDLE) && (bus.cpu_we ? !wbuf_full : wbuf_empty);
    push       = bus.cpu_valid && ready && bus.cpu_we;
    rd_accept  = bus.cpu_valid && ready && !bus.cpu_we;

    bus.cpu_ready = ready;
    bus.mem_we    = grant_wr;
    bus.mem_addr  = last_addr_q;
    bus.mem_wdata = last_wdata_q;
    if (grant_vga) begin
      bus.mem_addr = bus.vga_addr;
    end else if (grant_rd) begin
      bus.mem_addr = rd_addr_q;
    end else if (grant_wr) begin
      bus.mem_addr  = wbuf_addr_q[rd_ptr_q];
      bus.mem_wdata = wbuf_data_q[rd_ptr_q];
    end

    last_addr_d  = bus.mem_addr;
    last_wdata_d = bus.mem_wdata;
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = grant_wr ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q;
    if (push && !grant_wr) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && grant_wr) begin
      count_d = count_q - CNT_W'(1);
    end

    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    if (state_q == IDLE && rd_accept) begin
      state_d   = RD_PEND;
      rd_addr_d = bus.cpu_addr;
    end else if (state_q == RD_PEND && grant_rd) begin
      state_d = IDLE;
    end

    tag_p1_d  = grant_vga ? OWN_VGA : (grant_rd ? OWN_CPU : OWN_NONE);
    overrun_d = overrun_q || (bus.vga_req && vga_req_prev_q);

    // Stage p1 -> p2: SRAM data is valid now; steer it to whoever owned the slot.
    vga_valid_d  = (tag_p1_q == OWN_VGA);
    vga_data_d   = vga_valid_d ? bus.mem_rdata : vga_data_q;
    cpu_rvalid_d = (tag_p1_q == OWN_CPU);
    cpu_rdata_d  = cpu_rvalid_d ? bus.mem_rdata : cpu_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      tag_p1_q       <= OWN_NONE;
      rd_addr_q      <= '0;
      last_addr_q    <= '0;
      last_wdata_q   <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      vga_data_q     <= '0;
      vga_valid_q    <= 1'b0;
      cpu_rdata_q    <= '0;
      cpu_rvalid_q   <= 1'b0;
      vga_req_prev_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      tag_p1_q       <= tag_p1_d;
      rd_addr_q      <= rd_addr_d;
      last_addr_q    <= last_addr_d;
      last_wdata_q   <= last_wdata_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      vga_data_q     <= vga_data_d;
      vga_valid_q    <= vga_valid_d;
      cpu_rdata_q    <= cpu_rdata_d;
      cpu_rvalid_q   <= cpu_rvalid_d;
      vga_req_prev_q <= bus.vga_req;
      overrun_q      <= overrun_d;
    end
  end

  // Buffer storage carries no reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      wbuf_addr_q[wr_ptr_q] <= bus.cpu_addr;
      wbuf_data_q[wr_ptr_q] <= bus.cpu_wdata;
    end
  end

  assign bus.vga_data   = vga_data_q;
  assign bus.vga_valid  = vga_valid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign wbuf_count     = count_q;
  assign vga_overrun    = overrun_q;
endmodule
